// File: rtl/led_fx_pkg.sv
// Shared types and constants for the LED serial pattern link (PISO transmit end).
package led_fx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam logic DIR_RIGHT = 1'b1;  // LSB first
  localparam logic DIR_LEFT  = 1'b0;  // MSB first

  localparam logic [63:0] PISO_RESET_PATTERN = 64'h0;

endpackage

// File: rtl/led_pattern_piso_if.sv
// Load handshake and serial output bundle of the LED pattern PISO.
interface led_pattern_piso_if #(
  parameter int WIDTH = 8
);
  import led_fx_pkg::*;

  // Handshake: p_in/lr are captured on a clock edge where load=1 and ready=1;
  // load while ready=0 is dropped, nothing is queued.
  logic             load;
  logic [WIDTH-1:0] p_in;
  logic             lr;
  logic             ready;
  logic             s_out;
  logic             s_valid;
  logic             busy;
  logic             done;
  piso_state_e      state;

  modport master (
    output load, p_in, lr,
    input  ready, s_out, s_valid, busy, done, state
  );

  modport slave (
    input  load, p_in, lr,
    output ready, s_out, s_valid, busy, done, state
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clears on load, counts shifted bits, flags the last one.
module piso_bit_counter #(
  parameter int FRAME = 8,
  parameter int CW    = $clog2(FRAME + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(FRAME - 1));

endmodule

// File: rtl/led_pattern_piso.sv
// Parallel-in/serial-out transmitter for LED patterns, bit order chosen by lr.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module led_pattern_piso
  import led_fx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  led_pattern_piso_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic [WIDTH-1:0] shift_once(logic [WIDTH-1:0] v, logic d);
    return (d == DIR_LEFT) ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic head_bit(logic [WIDTH-1:0] v, logic d);
    return (d == DIR_RIGHT) ? v[0] : v[WIDTH-1];
  endfunction

  assign accept = (state_q == IDLE) && bus.load;

  piso_bit_counter #(.FRAME(FRAME), .CW(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .inc_i  ((state_q == SHIFT) && !last),
    .cnt_o  (cnt),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = SHIFT;
      SHIFT:   if (last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.busy  = (state_q != IDLE);
    bus.state = state_q;
  end

  // The bit for the next cycle is registered on the edge that reveals it, so
  // the first bit is already on s_out in the cycle right after the load.
  always_comb begin
    shreg_d   = shreg_q;
    dir_d     = dir_q;
    s_out_d   = 1'b0;
    s_valid_d = 1'b0;
    done_d    = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    if (accept) begin
      shreg_d   = shift_once(bus.p_in, bus.lr);
      dir_d     = bus.lr;
      s_out_d   = head_bit(bus.p_in, bus.lr);
      s_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d     = ^bus.p_in;
`endif
    end else if (state_q == SHIFT) begin
      if (last) begin
        done_d = 1'b1;
      end else begin
        s_valid_d = 1'b1;
        s_out_d   = head_bit(shreg_q, dir_q);
        shreg_d   = shift_once(shreg_q, dir_q);
`ifdef PISO_PARITY_EN
        if (cnt == CW'(WIDTH - 1)) s_out_d = par_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= WIDTH'(PISO_RESET_PATTERN);
      dir_q     <= DIR_RIGHT;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      shreg_q   <= shreg_d;
      dir_q     <= dir_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      done_q    <= done_d;
`ifdef PISO_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.s_out   = s_out_q;
  assign bus.s_valid = s_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_led_pattern_piso.sv
// Directed bench for led_pattern_piso: reset, both bit orders, busy/done-cycle
// loads, mid-frame reset and the parity/plain frame length.
module tb_led_pattern_piso;
  import led_fx_pkg::*;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] cap;
  logic [7:0]  sipo;

  led_pattern_piso_if #(.WIDTH(8)) bus ();

  led_pattern_piso #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_s_out"},   16'(bus.s_out),   16'd0);
    chk({tag, "_s_valid"}, 16'(bus.s_valid), 16'd0);
    chk({tag, "_busy"},    16'(bus.busy),    16'd0);
    chk({tag, "_done"},    16'(bus.done),    16'(exp_done));
    chk({tag, "_ready"},   16'(bus.ready),   16'd1);
    chk({tag, "_state"},   16'(bus.state),   16'(IDLE));
  endtask

  task automatic load_frame(input string tag, input logic [7:0] p, input logic lr_v);
    @(negedge clk);
    chk({tag, "_ready_at_load"}, 16'(bus.ready), 16'd1);
    bus.load = 1'b1;
    bus.p_in = p;
    bus.lr   = lr_v;
  endtask

  // seq bit k is the k-th serial bit (bit 8 = parity bit when enabled).
  // Returns in the negedge of the done cycle.
  task automatic expect_frame(input string tag, input logic [15:0] seq, input bit poke);
    cap = '0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) bus.load = 1'b0;
      cap[k] = bus.s_out;
      chk($sformatf("%s_bit%0d", tag, k),   16'(bus.s_out),   16'(seq[k]));
      chk($sformatf("%s_valid%0d", tag, k), 16'(bus.s_valid), 16'd1);
      chk($sformatf("%s_busy%0d", tag, k),  16'(bus.busy),    16'd1);
      chk($sformatf("%s_done%0d", tag, k),  16'(bus.done),    16'd0);
      if (poke && k == 2) begin
        bus.load = 1'b1;
        bus.p_in = 8'h81;
        bus.lr   = 1'b0;
      end else if (poke && k == 3) begin
        bus.load = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle({tag, "_donecyc"}, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.p_in = 8'h00;
    bus.lr   = 1'b0;

    // 1: reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst%0d", i), 1'b0);
      bus.load = ~bus.load;
      bus.p_in = bus.p_in ^ 8'hA5;
    end
    @(negedge clk);
    bus.load = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk_idle("post_rst", 1'b0);

    // 2: B4 LSB first -> 0,0,1,0,1,1,0,1 ; parity of B4 = 0
    load_frame("b4r", 8'hB4, 1'b1);
    expect_frame("b4r", 16'h00B4, 1'b0);
    sipo = '0;
    for (int k = 0; k < 8; k++) sipo = {cap[k], sipo[7:1]};
    chk("b4r_sipo", 16'(sipo), 16'h00B4);
    @(negedge clk);
    chk_idle("b4r_after", 1'b0);

    // 3: B4 MSB first -> 1,0,1,1,0,1,0,0
    load_frame("b4l", 8'hB4, 1'b0);
    expect_frame("b4l", 16'h002D, 1'b0);
    sipo = '0;
    for (int k = 0; k < 8; k++) sipo = {sipo[6:0], cap[k]};
    chk("b4l_sipo", 16'(sipo), 16'h00B4);

    // 4: 0F LSB first with 81 poked while busy, then 81 MSB first from the done cycle
    load_frame("0f", 8'h0F, 1'b1);
    expect_frame("0f", 16'h000F, 1'b1);
    bus.load = 1'b1;
    bus.p_in = 8'h81;
    bus.lr   = 1'b0;
    expect_frame("81", 16'h0081, 1'b0);
    @(negedge clk);
    chk_idle("81_after", 1'b0);

    // 5: async reset during a 3C MSB-first frame (0,0,1,1,...)
    load_frame("3c", 8'h3C, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.load = 1'b0;
      chk($sformatf("3c_bit%0d", k), 16'(bus.s_out), 16'(k >= 2));
      chk($sformatf("3c_valid%0d", k), 16'(bus.s_valid), 16'd1);
    end
    #2 reset = 1'b1;
    #1 chk_idle("mid_rst_async", 1'b0);
    @(negedge clk);
    chk_idle("mid_rst_held", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("no_done%0d", i), 16'(bus.done), 16'd0);
    end
    load_frame("a5", 8'hA5, 1'b1);
    expect_frame("a5", 16'h00A5, 1'b0);

    // 6: 07 LSB first; parity bit 1 appended when enabled
    load_frame("07", 8'h07, 1'b1);
    expect_frame("07", 16'h0107, 1'b0);
    @(negedge clk);
    chk_idle("07_after", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
